// File: rtl/gpio_pkg.sv
// Shared GPIO port definitions, used by both the input sampler and the port
// output register.
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH    = 8;
    localparam int unsigned GPIO_SYNC_MAX = 3;
    // Arm counter must hold GPIO_SYNC_MAX+1 without wrapping.
    localparam int unsigned GPIO_ARM_W    = $clog2(GPIO_SYNC_MAX + 2);

    typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;

endpackage

// File: rtl/gpio_sync_cell.sv
// N-stage single-bit synchronizer for an asynchronous pad input; all stages
// clear on the asynchronous reset.
module gpio_sync_cell #(
    parameter int unsigned P_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [P_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[P_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[P_STAGES-1];

endmodule

// File: rtl/gpio_pin_sampler.sv
// GPIO port input side: synchronized PINx read value, masked pin-change flags
// with write-1-to-clear / vector-acknowledge clear, and the port IRQ request.
module gpio_pin_sampler
    import gpio_pkg::*;
#(
    parameter int unsigned        P_WIDTH       = GPIO_WIDTH,
    parameter int unsigned        P_SYNC_STAGES = 2,
    parameter logic [P_WIDTH-1:0] P_IMPL_MASK   = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_WIDTH-1:0] pin_in,
    input  logic [P_WIDTH-1:0] pcmsk_wdata,
    input  logic               pcmsk_we,
    input  logic [P_WIDTH-1:0] pcif_wdata,
    input  logic               pcif_we,
    input  logic               irq_ack,
    output logic [P_WIDTH-1:0] pin_rdata,
    output logic [P_WIDTH-1:0] pcmsk_rdata,
    output logic [P_WIDTH-1:0] pcif_rdata,
    output logic               pcint_irq
);

    localparam logic [GPIO_ARM_W-1:0] ARM_DONE = GPIO_ARM_W'(P_SYNC_STAGES + 1);

    logic [P_WIDTH-1:0]    sync_out;
    logic [P_WIDTH-1:0]    prev_q,  prev_d;
    logic [P_WIDTH-1:0]    pcmsk_q, pcmsk_d;
    logic [P_WIDTH-1:0]    pcif_q,  pcif_d;
    logic [GPIO_ARM_W-1:0] arm_q,   arm_d;
    logic [P_WIDTH-1:0]    change;
    logic [P_WIDTH-1:0]    clr;
    logic                  armed;

    for (genvar i = 0; i < P_WIDTH; i++) begin : g_sync
        gpio_sync_cell #(
            .P_STAGES(P_SYNC_STAGES)
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .d_i(pin_in[i]),
            .q_o(sync_out[i])
        );
    end

    assign pin_rdata = sync_out & P_IMPL_MASK;

    // Changes are suppressed until the synchronizer and prev have both been
    // filled with real pad values, so pins high at reset release never flag.
    assign armed = (arm_q == ARM_DONE);

    always_comb begin
        arm_d   = armed ? arm_q : arm_q + 1'b1;
        prev_d  = pin_rdata;
        change  = armed ? ((pin_rdata ^ prev_q) & pcmsk_q & P_IMPL_MASK) : '0;
        clr     = (pcif_we ? pcif_wdata : '0) | (irq_ack ? '1 : '0);
        pcif_d  = (pcif_q & ~clr) | change;
        pcmsk_d = pcmsk_we ? (pcmsk_wdata & P_IMPL_MASK) : pcmsk_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q   <= '0;
            prev_q  <= '0;
            pcmsk_q <= '0;
            pcif_q  <= '0;
        end else begin
            arm_q   <= arm_d;
            prev_q  <= prev_d;
            pcmsk_q <= pcmsk_d;
            pcif_q  <= pcif_d;
        end
    end

    assign pcmsk_rdata = pcmsk_q;
    assign pcif_rdata  = pcif_q;
    assign pcint_irq   = |pcif_q;

endmodule
